// File: rtl/neureka_streamout_gather.sv
// Streamout gather: tracks PE/beat position of the serialized engine stream, drops
// border-tile PEs and forwards survivors through a 2-entry skid. Perf counters: NEUREKA_STREAMOUT_GATHER_PERF_EN.
`ifndef NEUREKA_PE_H_DEFAULT
`define NEUREKA_PE_H_DEFAULT 3
`endif
`ifndef NEUREKA_PE_W_DEFAULT
`define NEUREKA_PE_W_DEFAULT 3
`endif
`ifndef NEUREKA_MEM_BANDWIDTH
`define NEUREKA_MEM_BANDWIDTH 256
`endif

module neureka_streamout_gather #(
  parameter int unsigned PE_H       = `NEUREKA_PE_H_DEFAULT,
  parameter int unsigned PE_W       = `NEUREKA_PE_W_DEFAULT,
  parameter int unsigned DATA_WIDTH = `NEUREKA_MEM_BANDWIDTH,
  parameter int unsigned BEAT_CNT_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [$clog2(PE_H+1)-1:0]       h_valid_i,
  input  logic [$clog2(PE_W+1)-1:0]       w_valid_i,
  input  logic [BEAT_CNT_W-1:0]           beats_per_pe_i,
  input  logic                            push_valid_i,
  output logic                            push_ready_o,
  input  logic [DATA_WIDTH-1:0]           push_data_i,
  input  logic [DATA_WIDTH/8-1:0]         push_strb_i,
  output logic                            pop_valid_o,
  input  logic                            pop_ready_i,
  output logic [DATA_WIDTH-1:0]           pop_data_o,
  output logic [DATA_WIDTH/8-1:0]         pop_strb_o,
  output logic [$clog2(PE_H*PE_W)-1:0]    pe_idx_o,
  output logic [BEAT_CNT_W-1:0]           beat_idx_o,
  output logic                            last_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [15:0]                     drop_cnt_o,
  output logic [15:0]                     stall_cnt_o,
  output logic [1:0]                      dbg_state_o
);

  localparam int unsigned NR_PE = PE_H * PE_W;
  localparam int unsigned HW    = $clog2(PE_H + 1);
  localparam int unsigned WW    = $clog2(PE_W + 1);
  localparam int unsigned PW    = $clog2(NR_PE);
  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned EW    = 1 + PW + BEAT_CNT_W + SW + DATA_WIDTH;

  // Both streams: a beat transfers on a rising clock edge where valid && ready; a source
  // holding valid keeps its payload stable until that edge, and never waits on ready to raise valid.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                r_state, w_state_n;
  logic [BEAT_CNT_W-1:0] r_beat_cnt, w_beat_n, r_bpp, w_bpp_n;
  logic [PW-1:0]         r_pe_cnt, w_pe_n;
  logic [HW-1:0]         r_h_cnt, w_h_n, r_h_valid, w_hv_n;
  logic [WW-1:0]         r_w_cnt, w_w_n, r_w_valid, w_wv_n;
  logic                  r_push_ready, w_push_ready_n, r_err;
  logic [1:0]            r_sk_cnt, w_sk_cnt_n;
  logic [EW-1:0]         r_sk0, r_sk1, w_sk_in;

  logic w_start_ok, w_push_hs, w_keep, w_keep_n, w_push_kept, w_pop_hs;
  logic w_beat_wrap, w_pe_wrap, w_final_in, w_last_in, w_sk0_load, w_sk1_load;
  logic [HW-1:0] w_hv_clamp;
  logic [WW-1:0] w_wv_clamp;

  assign w_start_ok  = start_i && (r_state == S_IDLE) && (beats_per_pe_i != '0);
  assign w_push_hs   = push_valid_i && r_push_ready && (r_state == S_RUN);
  assign w_keep      = (r_h_cnt < r_h_valid) && (r_w_cnt < r_w_valid);
  assign w_push_kept = w_push_hs && w_keep;
  assign w_pop_hs    = pop_valid_o && pop_ready_i;
  assign w_beat_wrap = (r_beat_cnt == r_bpp - BEAT_CNT_W'(1));
  assign w_pe_wrap   = (r_pe_cnt == PW'(NR_PE - 1));
  assign w_final_in  = w_push_hs && w_beat_wrap && w_pe_wrap;
  assign w_last_in   = w_beat_wrap && (r_h_cnt == r_h_valid - HW'(1)) && (r_w_cnt == r_w_valid - WW'(1));
  assign w_hv_clamp  = (32'(h_valid_i) > PE_H) ? HW'(PE_H) : h_valid_i;
  assign w_wv_clamp  = (32'(w_valid_i) > PE_W) ? WW'(PE_W) : w_valid_i;
  assign w_sk_cnt_n  = r_sk_cnt + 2'(w_push_kept) - 2'(w_pop_hs);
  assign w_sk_in     = {w_last_in, r_pe_cnt, r_beat_cnt, push_strb_i, push_data_i};

  // Row/column counters walk alongside pe_cnt so the keep test needs no divider.
  always_comb begin
    w_beat_n = r_beat_cnt;
    w_pe_n   = r_pe_cnt;
    w_h_n    = r_h_cnt;
    w_w_n    = r_w_cnt;
    w_hv_n   = r_h_valid;
    w_wv_n   = r_w_valid;
    w_bpp_n  = r_bpp;
    if (w_start_ok) begin
      w_beat_n = '0;
      w_pe_n   = '0;
      w_h_n    = '0;
      w_w_n    = '0;
      w_hv_n   = w_hv_clamp;
      w_wv_n   = w_wv_clamp;
      w_bpp_n  = beats_per_pe_i;
    end else if (w_push_hs) begin
      if (!w_beat_wrap) begin
        w_beat_n = r_beat_cnt + BEAT_CNT_W'(1);
      end else begin
        w_beat_n = '0;
        if (w_pe_wrap) begin
          w_pe_n = '0;
          w_h_n  = '0;
          w_w_n  = '0;
        end else begin
          w_pe_n = r_pe_cnt + PW'(1);
          if (r_w_cnt == WW'(PE_W - 1)) begin
            w_w_n = '0;
            w_h_n = r_h_cnt + HW'(1);
          end else begin
            w_w_n = r_w_cnt + WW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_n = S_RUN;
      S_RUN:   if (w_final_in) w_state_n = S_DRAIN;
      S_DRAIN: if (w_sk_cnt_n == 2'd0) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Ready looks one beat ahead: a beat that will be dropped never needs skid space.
  assign w_keep_n       = (w_h_n < w_hv_n) && (w_w_n < w_wv_n);
  assign w_push_ready_n = (w_state_n == S_RUN) && ((w_sk_cnt_n != 2'd2) || !w_keep_n);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_pe_cnt     <= '0;
      r_h_cnt      <= '0;
      r_w_cnt      <= '0;
      r_h_valid    <= '0;
      r_w_valid    <= '0;
      r_bpp        <= '0;
      r_push_ready <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_beat_cnt   <= w_beat_n;
      r_pe_cnt     <= w_pe_n;
      r_h_cnt      <= w_h_n;
      r_w_cnt      <= w_w_n;
      r_h_valid    <= w_hv_n;
      r_w_valid    <= w_wv_n;
      r_bpp        <= w_bpp_n;
      r_push_ready <= w_push_ready_n;
      r_err        <= start_i && !w_start_ok;
    end
  end

  // Skid: entry 0 is the output register, entry 1 catches a beat while entry 0 is held.
  assign w_sk0_load = w_push_kept && (r_sk_cnt == (w_pop_hs ? 2'd1 : 2'd0));
  assign w_sk1_load = w_push_kept && (r_sk_cnt == (w_pop_hs ? 2'd2 : 2'd1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_sk_cnt <= 2'd0;
      r_sk0    <= '0;
      r_sk1    <= '0;
    end else begin
      r_sk_cnt <= w_sk_cnt_n;
      if (w_sk0_load)    r_sk0 <= w_sk_in;
      else if (w_pop_hs) r_sk0 <= r_sk1;
      if (w_sk1_load)    r_sk1 <= w_sk_in;
    end
  end

  assign pop_valid_o  = (r_sk_cnt != 2'd0);
  assign {last_o, pe_idx_o, beat_idx_o, pop_strb_o, pop_data_o} = r_sk0;
  assign push_ready_o = r_push_ready;
  assign busy_o       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

`ifdef NEUREKA_STREAMOUT_GATHER_PERF_EN
  logic [15:0] r_drop_cnt, r_stall_cnt;
  logic        w_push_drop, w_stall;

  assign w_push_drop = w_push_hs && !w_keep;
  assign w_stall     = busy_o && pop_valid_o && !pop_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i || w_start_ok) begin
      r_drop_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push_drop && (r_drop_cnt != 16'hFFFF))  r_drop_cnt  <= r_drop_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF))     r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign drop_cnt_o  = r_drop_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign drop_cnt_o  = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_neureka_streamout_gather.sv
// Bench for neureka_streamout_gather: random beats and pop backpressure, checked against
// a queue model built from the PE grid (keep iff row < h_valid and col < w_valid).
module tb_neureka_streamout_gather;

  localparam int PE_H  = 3;
  localparam int PE_W  = 3;
  localparam int DW    = 256;
  localparam int BW    = 8;
  localparam int NR_PE = PE_H * PE_W;
  localparam int HW    = $clog2(PE_H + 1);
  localparam int WW    = $clog2(PE_W + 1);
  localparam int PIW   = $clog2(NR_PE);
  localparam int SW    = DW / 8;
  localparam int DV    = SW + DW;
  localparam int EW    = 1 + PIW + BW + DV;
  localparam int CW    = 320;

  logic clk = 1'b0;
  logic rst_ni, clear_i, start_i;
  logic [HW-1:0] h_valid_i;
  logic [WW-1:0] w_valid_i;
  logic [BW-1:0] beats_per_pe_i;
  logic push_valid_i, push_ready_o, pop_valid_o, pop_ready_i;
  logic [DW-1:0] push_data_i, pop_data_o;
  logic [SW-1:0] push_strb_i, pop_strb_o;
  logic [PIW-1:0] pe_idx_o;
  logic [BW-1:0] beat_idx_o;
  logic last_o, busy_o, done_o, err_o;
  logic [15:0] drop_cnt_o, stall_cnt_o;
  logic [1:0] dbg_state_o;

  int checks = 0;
  int failures = 0;
  int stall_exp = 0;
  int done_seen = 0;
  int pop_valid_seen = 0;
  logic [EW-1:0] exp_q[$];
  logic [DV-1:0] drv_q[$];

  neureka_streamout_gather #(
    .PE_H(PE_H), .PE_W(PE_W), .DATA_WIDTH(DW), .BEAT_CNT_W(BW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .h_valid_i(h_valid_i), .w_valid_i(w_valid_i), .beats_per_pe_i(beats_per_pe_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_data_i(push_data_i), .push_strb_i(push_strb_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .pop_data_o(pop_data_o), .pop_strb_o(pop_strb_o),
    .pe_idx_o(pe_idx_o), .beat_idx_o(beat_idx_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .drop_cnt_o(drop_cnt_o), .stall_cnt_o(stall_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset-independent event counters
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_o) done_seen++;
    if (pop_valid_o) pop_valid_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DV-1:0] rand_beat();
    logic [DV-1:0] d;
    for (int k = 0; k < DV / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_reset();
    check("rst_pop_valid",  CW'(pop_valid_o), CW'(0));
    check("rst_pop_data",   CW'(pop_data_o), CW'(0));
    check("rst_pop_strb",   CW'(pop_strb_o), CW'(0));
    check("rst_push_ready", CW'(push_ready_o), CW'(0));
    check("rst_pe_idx",     CW'(pe_idx_o), CW'(0));
    check("rst_beat_idx",   CW'(beat_idx_o), CW'(0));
    check("rst_last",       CW'(last_o), CW'(0));
    check("rst_busy",       CW'(busy_o), CW'(0));
    check("rst_done",       CW'(done_o), CW'(0));
    check("rst_err",        CW'(err_o), CW'(0));
    check("rst_drop_cnt",   CW'(drop_cnt_o), CW'(0));
    check("rst_stall_cnt",  CW'(stall_cnt_o), CW'(0));
    check("rst_state_idle", CW'(dbg_state_o), CW'(0));
  endtask

  // driver: one beat, bounded wait for ready, returns just after the accepting edge
  task automatic push_beat(input logic [DV-1:0] b, input int gap_pct);
    int n = 0;
    @(negedge clk);
    if (int'($urandom_range(0, 99)) < gap_pct) begin
      push_valid_i = 1'b0;
      @(negedge clk);
    end
    push_valid_i = 1'b1;
    {push_strb_i, push_data_i} = b;
    while (!push_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!push_ready_o) check("push_ready_timeout", CW'(push_ready_o), CW'(1));
    @(posedge clk);
  endtask

  task automatic drive(input int gap_pct);
    logic [DV-1:0] b;
    while (drv_q.size() > 0) begin
      b = drv_q.pop_front();
      push_beat(b, gap_pct);
    end
    @(negedge clk);
    push_valid_i = 1'b0;
  endtask

  // scoreboard side: random pop ready, every valid cycle compared to the queue head
  task automatic monitor(input int ready_pct);
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
      pop_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
      if (pop_valid_o) begin
        check("pop_beat", CW'({last_o, pe_idx_o, beat_idx_o, pop_strb_o, pop_data_o}), CW'(exp_q[0]));
        if (!pop_ready_i && busy_o) stall_exp++;
        if (pop_ready_i) void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() > 0) check("pop_timeout_left", CW'(exp_q.size()), CW'(0));
  endtask

  task automatic run_tile(input int hv, input int wv, input int bpp, input int ready_pct,
                          input int gap_pct, input bit restart);
    int kept = 0;
    int done0, pv0, n;
    logic [DV-1:0] d;
    logic [EW-1:0] e;
    exp_q.delete();
    drv_q.delete();
    stall_exp = 0;
    for (int pe = 0; pe < NR_PE; pe++) begin
      for (int b = 0; b < bpp; b++) begin
        d = rand_beat();
        drv_q.push_back(d);
        if ((pe / PE_W) < hv && (pe % PE_W) < wv) begin
          exp_q.push_back({1'b0, PIW'(pe), BW'(b), d});
          kept++;
        end
      end
    end
    if (kept > 0) begin
      e = exp_q.pop_back();
      e[EW-1] = 1'b1;
      exp_q.push_back(e);
    end
    done0 = done_seen;
    @(negedge clk);
    h_valid_i = HW'(hv);
    w_valid_i = WW'(wv);
    beats_per_pe_i = BW'(bpp);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", CW'(busy_o), CW'(1));
    if (restart) begin
      start_i = 1'b1;
      h_valid_i = '0;
      beats_per_pe_i = BW'(1);
      @(negedge clk);
      start_i = 1'b0;
      check("err_on_busy_start", CW'(err_o), CW'(1));
      check("busy_after_restart", CW'(busy_o), CW'(1));
    end
    pv0 = pop_valid_seen;
    fork
      drive(gap_pct);
      monitor(ready_pct);
    join
    n = 0;
    while (done_seen == done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", CW'(done_seen - done0), CW'(1));
    check("busy_after_done", CW'(busy_o), CW'(0));
`ifdef NEUREKA_STREAMOUT_GATHER_PERF_EN
    check("drop_cnt", CW'(drop_cnt_o), CW'(NR_PE * bpp - kept));
    check("stall_cnt", CW'(stall_cnt_o), CW'(stall_exp));
`else
    check("drop_cnt", CW'(drop_cnt_o), CW'(0));
    check("stall_cnt", CW'(stall_cnt_o), CW'(0));
`endif
    if (kept == 0) check("empty_no_pop_valid", CW'(pop_valid_seen - pv0), CW'(0));
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    h_valid_i = '0;
    w_valid_i = '0;
    beats_per_pe_i = '0;
    push_valid_i = 1'b1;
    {push_strb_i, push_data_i} = rand_beat();
    pop_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst_ni = 1'b1;
    push_valid_i = 1'b0;

    run_tile(3, 3, 2, 100, 0, 1'b0);  // full tile
    run_tile(2, 1, 2, 100, 0, 1'b0);  // border tile: PEs 0 and 3
    run_tile(3, 3, 2, 30, 0, 1'b0);   // backpressure
    run_tile(0, 3, 2, 100, 0, 1'b0);  // empty tile

    // bad start: zero beats per PE
    @(negedge clk);
    h_valid_i = HW'(3);
    w_valid_i = WW'(3);
    beats_per_pe_i = '0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("err_zero_beats", CW'(err_o), CW'(1));
    check("busy_zero_beats", CW'(busy_o), CW'(0));
    @(negedge clk);
    check("err_single_pulse", CW'(err_o), CW'(0));
    check("busy_stays_idle", CW'(busy_o), CW'(0));

    for (int t = 0; t < 4; t++) begin
      run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               int'($urandom_range(20, 100)), 20, (t == 0));
    end

    // clear after 7 beats, then a fresh tile must start at (0,0)
    pop_ready_i = 1'b1;
    @(negedge clk);
    h_valid_i = HW'(3);
    w_valid_i = WW'(3);
    beats_per_pe_i = BW'(2);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) push_beat(rand_beat(), 0);
    @(negedge clk);
    push_valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clear_busy", CW'(busy_o), CW'(0));
    check("clear_pop_valid", CW'(pop_valid_o), CW'(0));
    check("clear_push_ready", CW'(push_ready_o), CW'(0));
    run_tile(3, 3, 2, 100, 0, 1'b0);

    // reset while a beat (PE 3) is held on the output
    pop_ready_i = 1'b1;
    @(negedge clk);
    h_valid_i = HW'(3);
    w_valid_i = WW'(3);
    beats_per_pe_i = BW'(1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(rand_beat(), 0);
    @(negedge clk);
    push_valid_i = 1'b0;
    pop_ready_i = 1'b0;
    check("held_pop_valid", CW'(pop_valid_o), CW'(1));
    check("held_pe_idx", CW'(pe_idx_o), CW'(3));
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset();
    rst_ni = 1'b1;
    pop_ready_i = 1'b1;
    run_tile(3, 3, 2, 50, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
